mem_port_arbiter: RTL

Shares the single read/write data port of the unified memory between the instruction-fetch unit and the load/store unit in the single-port FPGA build. Each cycle it grants at most one request, drives the memory port combinationally, and captures the read result into a per-requester response slot. Data requests take priority, and a starvation counter bounds the instruction-fetch wait. It sits between the core's IF/MEM stages and the memory's data port; the memory's instruction port is left unused in this build.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_resp_slot.sv | 27 ++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
package mem_arb_pkg;

   // Load type the instruction fetch always issues (full word).
   localparam logic [2:0] LT_WORD = 3'b010;

   // Width of the instruction-fetch starvation counter.
   localparam int STARVE_W = 4;

   // Saturation value of the starvation counter.
   localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

   // Which requester currently owns the memory port.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

endpackage

// File: rtl/arb_resp_slot.sv
// One-entry response holding register for a single requester.
module arb_resp_slot #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  rready,
   output logic                  rvalid,
   output logic [DATA_WIDTH-1:0] rdata
);

   // A new grant reloads the slot; otherwise a handshake empties it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else if (load) begin
         rvalid <= 1'b1;
         rdata  <= load_data;
      end else if (rvalid && rready) begin
         rvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory data port between instruction fetch and load/store.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  i_rready,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   input  logic [3:0]            d_be,
   input  logic [2:0]            d_load_type,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   input  logic                  d_rready,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_wdata,
   output logic [3:0]            m_be,
   output logic [2:0]            m_load_type,
   output logic                  m_we,
   output logic                  m_re,
   input  logic [DATA_WIDTH-1:0] m_rdata
);

   owner_e                owner;
   logic                  i_elig;
   logic                  d_elig;
   logic                  starved;
   logic [STARVE_W-1:0]   starve_cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [2:0]            lt_q;
   logic [DATA_WIDTH-1:0] d_load_data;

   // A port can take the memory if its slot is empty or is being drained now.
   assign i_elig  = i_req && (!i_rvalid || i_rready);
   assign d_elig  = d_req && (!d_rvalid || d_rready);
   assign starved = (starve_cnt >= STARVE_W'(STARVE_LIMIT));

   // Data wins ties until fetch has waited too long; nothing is granted in reset.
   always_comb begin
      owner = OWN_NONE;
      if (rst) begin
         owner = OWN_NONE;
      end else if (d_elig && i_elig) begin
         owner = starved ? OWN_I : OWN_D;
      end else if (d_elig) begin
         owner = OWN_D;
      end else if (i_elig) begin
         owner = OWN_I;
      end
   end

   assign i_gnt = (owner == OWN_I);
   assign d_gnt = (owner == OWN_D);

   // Memory-side mux; idle cycles keep the last address, data and load type.
   always_comb begin
      m_addr      = addr_q;
      m_wdata     = wdata_q;
      m_load_type = lt_q;
      m_be        = 4'h0;
      m_we        = 1'b0;
      m_re        = 1'b0;
      case (owner)
         OWN_I: begin
            m_addr      = i_addr;
            m_load_type = LT_WORD;
            m_re        = 1'b1;
         end
         OWN_D: begin
            m_addr      = d_addr;
            m_wdata     = d_wdata;
            m_load_type = d_load_type;
            m_we        = d_we;
            m_re        = !d_we;
            m_be        = d_we ? d_be : 4'h0;
         end
         default: begin
         end
      endcase
   end

   // Remember the last granted address, write data and load type for idle cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         lt_q    <= 3'b000;
      end else if (owner != OWN_NONE) begin
         addr_q  <= m_addr;
         wdata_q <= m_wdata;
         lt_q    <= m_load_type;
      end
   end

   // Count consecutive cycles fetch was eligible but lost, saturating at the top.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!i_req || i_gnt) begin
         starve_cnt <= '0;
      end else if (i_elig && (starve_cnt != STARVE_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // A granted write returns zero as its acknowledgement.
   assign d_load_data = d_we ? '0 : m_rdata;

   arb_resp_slot #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_i_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (i_gnt),
      .load_data (m_rdata),
      .rready    (i_rready),
      .rvalid    (i_rvalid),
      .rdata     (i_rdata)
   );

   arb_resp_slot #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_d_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (d_gnt),
      .load_data (d_load_data),
      .rready    (d_rready),
      .rvalid    (d_rvalid),
      .rdata     (d_rdata)
   );

endmodule
